runner_hit_ctrl: RTL
====================

# runner_hit_ctrl

Game-flow controller that sequences the running-man collision check once per video frame. It turns the combinational `collision` flag into lives, invulnerability windows, score and game-over state, and gates the runner/obstacle movement logic through `run_enable`. It sits between the frame-rate tick generator, the collision detector and the HUD/VGA drawing logic.

## Interface
- `LIVES`, default 3: lives loaded at game start; legal range 1–3.
- `INVULN_FRAMES`, default 30: frames of collision immunity after a hit; must be ≥ 1.
- `SCORE_W`, default 16: width of the score and high-score registers.
- `clk` input 1: system clock; every register updates on its rising edge.
- `resetn` input 1: synchronous, active-low reset.
- `start` input 1: start key, level. A rising edge is detected internally.
- `frame_tick` input 1: one-cycle pulse, once per frame.
- `collision` input 1: collision detector output. Valid on the cycle where `frame_tick` = 1.
- `state` output 2: IDLE = 00, RUN = 01, INVULN = 10, OVER = 11.
- `lives` output 2: remaining lives.
- `score` output SCORE_W: frames survived in the current game.
- `high_score` output SCORE_W: best final score since reset.
- `run_enable` output 1: high in RUN and INVULN.
- `invuln` output 1: high in INVULN; drives the sprite-flash logic.
- `hit_pulse` output 1: one-cycle pulse per accepted hit.
- `game_over` output 1: high in OVER.

## Operation
- All outputs are registered.
- Reset values:
  - state = IDLE, lives = LIVES, score = 0, high_score = 0.
  - All 1-bit outputs = 0.
  - Start-edge register = 0, invulnerability counter = 0.
- Start edge: `start_rise = start & ~start_q`. `start_q` is registered every cycle. A held key therefore produces exactly one edge.
- IDLE:
  - `start_rise` → RUN; lives = LIVES; score = 0.
  - `frame_tick` and `collision` are ignored.
- RUN, on a cycle with `frame_tick`:
  - `collision` = 0: score += 1, saturating at 2^SCORE_W − 1.
  - `collision` = 1: lives −= 1 and `hit_pulse` = 1; score is not incremented.
    - If lives was 1 → OVER with lives = 0.
    - Otherwise → INVULN with counter = INVULN_FRAMES.
- RUN, on a cycle without `frame_tick`: hold. A `collision` outside a tick is ignored.
- INVULN:
  - `collision` is ignored.
  - Each `frame_tick`: score += 1 (saturating) and counter −= 1.
  - A tick arriving while counter = 1 → RUN with counter = 0.
- Entry to OVER: if score > high_score, high_score = score (unsigned compare), updated on the same edge as the state change.
- OVER:
  - score is frozen and `run_enable` = 0.
  - `start_rise` → RUN directly; lives = LIVES, score = 0, high_score kept.
- Unused encodings: none; all four states are used.
- Simultaneous events:
  - `start_rise` in RUN or INVULN has no effect.
  - `resetn` = 0 overrides everything on that edge, including a hit in flight. After reset the state is IDLE and `hit_pulse` = 0.

## Timing
- Latency: 1 cycle from the input edge (tick, or start rising edge) to updated state and outputs.
- `hit_pulse` is high for exactly the one cycle after the accepting tick edge. There is at most one pulse per frame.
- INVULN lasts exactly INVULN_FRAMES ticks. The RUN state is visible after the last tick edge. The first tick that can register a hit is tick INVULN_FRAMES + 1 counted from the hit tick.
- `run_enable`, `invuln` and `game_over` change on the same edge as `state`.
- There is no handshake with the collision detector; the only requirement is that `collision` is stable during the tick cycle.

## Test plan
Parameters for all scenarios: LIVES = 3, INVULN_FRAMES = 4.

- **Reset and start.** Hold `resetn` = 0 for 2 cycles, then hold `start` = 1 for 10 cycles. Required: exactly one transition IDLE → RUN, lives = 3, score = 0, `run_enable` = 1 one cycle after the edge.
- **Scoring.** In RUN, 5 ticks with `collision` = 0, plus `collision` = 1 on non-tick cycles. Required: score = 5, lives = 3, `hit_pulse` never asserted.
- **Hit and invulnerability window.** Tick with `collision` = 1. Required:
  - lives = 2, a single `hit_pulse`, state = INVULN.
  - The next 4 ticks carry `collision` = 1: lives stays 2, score rises by 4, state = RUN after the 4th tick.
  - A 5th tick with `collision` = 1 gives lives = 1.
- **Game over and high score.** Score 7, then three spaced hits. Required:
  - The third hit gives OVER with lives = 0, `game_over` = 1, `run_enable` = 0, `high_score` = score at the hit.
  - Further ticks leave score unchanged.
- **Restart keeps the high score.** From OVER, pulse `start`. Required: RUN, lives = 3, score = 0, high_score unchanged. A later lower final score leaves high_score unchanged.
- **Reset mid-invulnerability and saturation.** Assert `resetn` = 0 in INVULN. Required: IDLE, all outputs at reset values. Then with SCORE_W = 4, run 20 clean ticks: score stops at 15.

Source files
------------

// File: rtl/runner_hit_ctrl.sv
// Per-frame game-flow controller for the running-man game: converts the collision
// flag into lives, invulnerability windows, score, high score and game-over state.
module runner_hit_ctrl #(
    parameter int unsigned LIVES         = 3,
    parameter int unsigned INVULN_FRAMES = 30,
    parameter int unsigned SCORE_W       = 16
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic               frame_tick,
    input  logic               collision,
    output logic [1:0]         state,
    output logic [1:0]         lives,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] high_score,
    output logic               run_enable,
    output logic               invuln,
    output logic               hit_pulse,
    output logic               game_over
);

    localparam int unsigned CNT_W = $clog2(INVULN_FRAMES + 1);
    localparam logic [CNT_W-1:0]   CNT_INIT   = CNT_W'(INVULN_FRAMES);
    localparam logic [1:0]         LIVES_INIT = 2'(LIVES);
    localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_INVULN = 2'b10,
        ST_OVER   = 2'b11
    } state_e;

    state_e             state_q, state_d;
    logic [1:0]         lives_q, lives_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [SCORE_W-1:0] high_q, high_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               start_q;
    logic               hit_q, hit_d;
    logic               run_en_q, run_en_d;
    logic               invuln_q, invuln_d;
    logic               over_q, over_d;

    logic               start_rise;
    logic [SCORE_W-1:0] score_inc;

    assign start_rise = start & ~start_q;
    assign score_inc  = (score_q == SCORE_MAX) ? score_q : score_q + SCORE_W'(1);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            lives_q  <= LIVES_INIT;
            score_q  <= '0;
            high_q   <= '0;
            cnt_q    <= '0;
            start_q  <= 1'b0;
            hit_q    <= 1'b0;
            run_en_q <= 1'b0;
            invuln_q <= 1'b0;
            over_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            lives_q  <= lives_d;
            score_q  <= score_d;
            high_q   <= high_d;
            cnt_q    <= cnt_d;
            start_q  <= start;
            hit_q    <= hit_d;
            run_en_q <= run_en_d;
            invuln_q <= invuln_d;
            over_q   <= over_d;
        end
    end

    // Next-state logic; the status flags are decoded from state_d so they
    // change on the same edge as the state register.
    always_comb begin
        state_d = state_q;
        lives_d = lives_q;
        score_d = score_q;
        high_d  = high_q;
        cnt_d   = cnt_q;
        hit_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_rise) begin
                    state_d = ST_RUN;
                    lives_d = LIVES_INIT;
                    score_d = '0;
                end
            end
            ST_RUN: begin
                if (frame_tick) begin
                    if (collision) begin
                        hit_d = 1'b1;
                        if (lives_q == 2'd1) begin
                            state_d = ST_OVER;
                            lives_d = 2'd0;
                            if (score_q > high_q) begin
                                high_d = score_q;
                            end
                        end else begin
                            state_d = ST_INVULN;
                            lives_d = lives_q - 2'd1;
                            cnt_d   = CNT_INIT;
                        end
                    end else begin
                        score_d = score_inc;
                    end
                end
            end
            ST_INVULN: begin
                if (frame_tick) begin
                    score_d = score_inc;
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            ST_OVER: begin
                if (start_rise) begin
                    state_d = ST_RUN;
                    lives_d = LIVES_INIT;
                    score_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        run_en_d = (state_d == ST_RUN) || (state_d == ST_INVULN);
        invuln_d = (state_d == ST_INVULN);
        over_d   = (state_d == ST_OVER);
    end

    assign state      = state_q;
    assign lives      = lives_q;
    assign score      = score_q;
    assign high_score = high_q;
    assign run_enable = run_en_q;
    assign invuln     = invuln_q;
    assign hit_pulse  = hit_q;
    assign game_over  = over_q;

endmodule
